// File: rtl/rgb_pkg.sv
// Shared constants and types for the rgb_1 pixel colour stage.
`default_nettype none
`timescale 1ns/1ps
package rgb_pkg;

  localparam int COLOR_W_DEFAULT  = 4;
  localparam int DEBOUNCE_DEFAULT = 16;
  localparam int NUM_CH           = 3;

  localparam logic [COLOR_W_DEFAULT-1:0] COLOR_ON  = 4'hF;
  localparam logic [COLOR_W_DEFAULT-1:0] COLOR_OFF = 4'h0;

  // Bit position of each colour channel in the enable / button vectors.
  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

endpackage
`default_nettype wire

// File: rtl/rgb_1_button_debounce.sv
// One push-button path: 2-flop synchronizer, stability debouncer, rising-edge pulse.
`default_nettype none
`timescale 1ns/1ps
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q,  rise_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // The counter only advances while the synchronized input disagrees with
  // the accepted level; any agreeing cycle restarts the qualification.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;

endmodule
`default_nettype wire

// File: rtl/rgb_1.sv
// Pixel colour stage: button-toggled channel enables gate the font pixel onto registered R/G/B.
`default_nettype none
`timescale 1ns/1ps
module rgb_1
  import rgb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int COLOR_W         = COLOR_W_DEFAULT
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BotonR,
  input  logic               BotonG,
  input  logic               BotonB,
  input  logic               BIT_FUENTE,
  input  logic               H_ON,
  input  logic               V_ON,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               R2,
  output logic               G2,
  output logic               B2
);

  localparam logic [COLOR_W-1:0] C_ON  = {COLOR_W{COLOR_ON[0]}};
  localparam logic [COLOR_W-1:0] C_OFF = {COLOR_W{COLOR_OFF[0]}};

  logic [NUM_CH-1:0] btn_raw;
  logic [NUM_CH-1:0] btn_level;
  logic [NUM_CH-1:0] btn_rise;
  logic [NUM_CH-1:0] en_q, en_d;

  logic [COLOR_W-1:0] r_q, r_d;
  logic [COLOR_W-1:0] g_q, g_d;
  logic [COLOR_W-1:0] b_q, b_d;
  logic               fg_on;

  assign btn_raw[CH_R] = BotonR;
  assign btn_raw[CH_G] = BotonG;
  assign btn_raw[CH_B] = BotonB;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .CLK      (CLK),
      .RESET    (RESET),
      .btn_in   (btn_raw[i]),
      .btn_level(btn_level[i]),
      .btn_rise (btn_rise[i])
    );
  end

  // The rise pulse is only ever asserted alongside a high accepted level.
  always_comb begin
    en_d = en_q ^ (btn_rise & btn_level);
  end

  always_comb begin
    fg_on = H_ON & V_ON & BIT_FUENTE;
    r_d   = (fg_on & en_q[CH_R]) ? C_ON : C_OFF;
    g_d   = (fg_on & en_q[CH_G]) ? C_ON : C_OFF;
    b_d   = (fg_on & en_q[CH_B]) ? C_ON : C_OFF;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en_q <= '0;
      r_q  <= C_OFF;
      g_q  <= C_OFF;
      b_q  <= C_OFF;
    end else begin
      en_q <= en_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
    end
  end

  assign R  = r_q;
  assign G  = g_q;
  assign B  = b_q;
  assign R2 = en_q[CH_R];
  assign G2 = en_q[CH_G];
  assign B2 = en_q[CH_B];

endmodule
`default_nettype wire

// File: tb/tb_rgb_1.sv
// Self-checking bench for rgb_1: vector table for the pixel mux, sequences for buttons and reset.
`default_nettype none
`timescale 1ns/1ps
module tb_rgb_1;

  localparam int D = 16;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       BotonR, BotonG, BotonB;
  logic       BIT_FUENTE, H_ON, V_ON;
  logic [3:0] R, G, B;
  logic       R2, G2, B2;

  int total = 0;
  int bad   = 0;

  logic [2:0]  m_en;         // expected enables, bit0=R bit1=G bit2=B
  logic [11:0] sb_q[$];      // expected {R,G,B} awaiting the next registered output

  typedef struct {
    logic        h;
    logic        v;
    logic        f;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs[8];

  always #5 CLK = ~CLK;

  rgb_1 #(
    .DEBOUNCE_CYCLES(D),
    .COLOR_W        (4)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BotonR    (BotonR),
    .BotonG    (BotonG),
    .BotonB    (BotonB),
    .BIT_FUENTE(BIT_FUENTE),
    .H_ON      (H_ON),
    .V_ON      (V_ON),
    .R         (R),
    .G         (G),
    .B         (B),
    .R2        (R2),
    .G2        (G2),
    .B2        (B2)
  );

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pix(input logic [2:0] en, input logic h, input logic v,
                                      input logic f);
    logic       on;
    logic [3:0] rr, gg, bb;
    on = h & v & f;
    rr = (on && en[0]) ? 4'hF : 4'h0;
    gg = (on && en[1]) ? 4'hF : 4'h0;
    bb = (on && en[2]) ? 4'hF : 4'h0;
    return {rr, gg, bb};
  endfunction

  function automatic logic [11:0] ind();
    return {9'd0, B2, G2, R2};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sb_check(input string name);
    logic [11:0] e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got empty scoreboard expected one entry", name);
    end else begin
      e = sb_q.pop_front();
      chk(name, {R, G, B}, e);
    end
  endtask

  task automatic drive_pix(input string name, input logic h, input logic v, input logic f,
                           input logic [11:0] exp);
    H_ON       = h;
    V_ON       = v;
    BIT_FUENTE = f;
    sb_q.push_back(exp);
    step();
    sb_check(name);
  endtask

  task automatic set_btn(input int idx, input logic val);
    case (idx)
      0:       BotonR = val;
      1:       BotonG = val;
      default: BotonB = val;
    endcase
  endtask

  // Press, hold, release one button; check exact toggle latency and no re-toggle.
  task automatic press(input int idx, input string name);
    logic [2:0] old_en, new_en;
    old_en     = m_en;
    new_en     = m_en ^ (3'b001 << idx);
    H_ON       = 1'b1;
    V_ON       = 1'b1;
    BIT_FUENTE = 1'b1;
    set_btn(idx, 1'b1);
    for (int i = 1; i <= D + 4; i++) begin
      if (i >= D + 3) sb_q.push_back((i == D + 3) ? pix(old_en, 1, 1, 1) : pix(new_en, 1, 1, 1));
      step();
      if (i == D + 2) chk({name, "_ind_before"}, ind(), {9'd0, old_en});
      if (i == D + 3) begin
        chk({name, "_ind_toggle"}, ind(), {9'd0, new_en});
        sb_check({name, "_pix_before"});
      end
      if (i == D + 4) sb_check({name, "_pix_after"});
    end
    repeat (2 * D) step();
    chk({name, "_held"}, ind(), {9'd0, new_en});
    set_btn(idx, 1'b0);
    repeat (D + 5) step();
    chk({name, "_released"}, ind(), {9'd0, new_en});
    m_en = new_en;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 12'hFFF};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 12'h000};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 12'h000};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 12'h000};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 12'hFFF};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 12'h000};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 12'h000};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 12'hFFF};

    // Reset held with every input high.
    RESET      = 1'b1;
    BotonR     = 1'b1;
    BotonG     = 1'b1;
    BotonB     = 1'b1;
    BIT_FUENTE = 1'b1;
    H_ON       = 1'b1;
    V_ON       = 1'b1;
    m_en       = 3'b000;
    repeat (3) step();
    chk("reset_rgb", {R, G, B}, 12'h000);
    chk("reset_ind", ind(), 12'h000);
    BotonR = 1'b0;
    BotonG = 1'b0;
    BotonB = 1'b0;
    #3;
    RESET = 1'b0;
    drive_pix("post_reset_pix", 1, 1, 1, 12'h000);
    chk("post_reset_ind", ind(), 12'h000);

    press(0, "press_r");
    press(1, "press_g");
    press(2, "press_b");
    chk("all_enabled", ind(), 12'h007);

    for (int i = 0; i < 8; i++) begin
      drive_pix($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].f, vecs[i].exp_rgb);
    end

    // Async reset between clock edges.
    @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    chk("async_rst_rgb", {R, G, B}, 12'h000);
    chk("async_rst_ind", ind(), 12'h000);
    #2;
    RESET = 1'b0;
    m_en  = 3'b000;
    sb_q.push_back(pix(m_en, 1, 1, 1));
    step();
    sb_check("after_async_rst_pix");
    chk("after_async_rst_ind", ind(), 12'h000);

    // Short pulses on G must be rejected.
    for (int p = 0; p < 3; p++) begin
      BotonG = 1'b1;
      repeat (D - 2) step();
      BotonG = 1'b0;
      repeat (D) step();
      chk($sformatf("bounce%0d", p), ind(), 12'h000);
    end

    press(1, "stable_g_on");
    press(1, "stable_g_off");
    drive_pix("final_pix", 1, 1, 1, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
